id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode control unit; captures its control bundle plus decoded operands each cycle and presents them to the execute stage.
- Owns load-use hazard detection (EX holds a load whose rd feeds the ID instruction) and inserts a one-cycle bubble while requesting upstream freeze.
- Honours branch/jump flush from EX and hold requests from later stages.

Parameters:
- XLEN, 32, datapath width (PC, register data, immediate).
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_ResultSrc  in  2  control bundle from decode.
- id_MemWrite  in  2  control bundle from decode.
- id_ALUSrc1  in  1  control bundle from decode.
- id_ALUSrc2  in  1  control bundle from decode.
- id_RegWrite  in  1  control bundle from decode.
- id_ALUControl  in  4  control bundle from decode.
- id_MemRead  in  3  control bundle from decode.
- id_br_type  in  3  control bundle from decode.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands.
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- flush  in  1  branch/jump taken in EX; kill ID->EX transfer.
- hold  in  1  downstream stall; freeze this register.
- ex_valid  out  1  EX slot valid.
- ex_ResultSrc, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2, ex_RegWrite, ex_ALUControl, ex_MemRead, ex_br_type  out  same widths as id_*  registered control.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  RA_W  registered addresses.
- load_use_stall  out  1  freeze PC and IF/ID this cycle (combinational).

Behaviour:
- Reset: every ex_* output 0 (ex_valid=0, all control fields 0, data/address 0); counter (if present) 0.
- Load-use detect: load_use_stall = id_valid & ex_valid & ex_RegWrite & (ex_ResultSrc==2'b01) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Forced 0 when flush or hold is 1.
- Per-edge priority (highest first):
  - rst -> reset values.
  - flush -> bubble.
  - hold -> all ex_* keep previous values.
  - load_use_stall -> bubble.
  - otherwise -> capture every id_* into ex_*; ex_valid = id_valid.
- Bubble: ex_valid=0, ex_RegWrite=0, ex_MemWrite=00, ex_MemRead=000, ex_br_type=000, ex_ResultSrc=00, ex_ALUControl=0000, ex_ALUSrc1/2=0, ex_rd=0. Data fields and ex_rs1/ex_rs2 also 0.
- Invalid capture: capture with id_valid=0 clears all control write-enables exactly as a bubble, so no side effects leak from an invalid slot.
- Latency: one cycle ID->EX. A load-use bubble costs exactly one cycle; the next cycle the load sits in MEM and the condition clears.
- Boundary conditions:
  - rd=x0 never stalls.
  - Flush coincident with a load-use hit yields a single bubble with load_use_stall=0.
  - Hold overrides load-use, so no double-count.
  - rst mid-hold clears immediately.

Optional Feature:
- Macro LUMOS_HAZARD_CNT_EN.
- Defined: adds outputs bubble_cnt (32, out) and flush_cnt (32, out). bubble_cnt increments on each edge a load-use bubble is inserted; flush_cnt increments on each flush edge. Counters wrap at 2^32-1 -> 0, are cleared by rst, and are frozen while hold=1 unless flush is also 1.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles with random id_* -> all ex_* = 0, load_use_stall=0.
- Plain capture: id_valid=1, id_pc=0x100, id_RegWrite=1, id_ALUControl=0101, id_rd=7 -> next cycle ex_pc=0x100, ex_ALUControl=0101, ex_rd=7, ex_valid=1.
- Load-use: EX holds lw x5 (RegWrite=1, ResultSrc=01, rd=5); ID add reads rs2=5 with id_use_rs2=1 -> load_use_stall=1 for exactly 1 cycle, EX gets a bubble (ex_valid=0, ex_RegWrite=0), then add captured. Same case with rd=0 or id_use_rs2=0 -> no stall.
- Flush: flush=1 while ID has sw (MemWrite=11) -> ex_MemWrite=00, ex_valid=0. Flush together with a load-use hit -> one bubble, load_use_stall=0.
- Hold: hold=1 for 3 cycles while id_* changes -> ex_* unchanged. Hold with a load-use hit -> load_use_stall=0 and no bubble.
- With LUMOS_HAZARD_CNT_EN: 4 load-use bubbles and 2 flushes -> bubble_cnt=4, flush_cnt=2. Preload bubble_cnt=0xFFFFFFFF, then one bubble -> bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decode control bundle and operands each cycle and presents
// them to execute. Detects a load in EX whose rd feeds the ID instruction,
// inserts a one-cycle bubble and asks the front end to freeze.
// Edge priority: rst > flush > hold > load-use bubble > capture.
// Optional hazard counters (bubble_cnt, flush_cnt) are built when
// LUMOS_HAZARD_CNT_EN is defined; the default build omits them entirely.
module id_ex_pipe_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [1:0]      id_ResultSrc,
  input  logic [1:0]      id_MemWrite,
  input  logic            id_ALUSrc1,
  input  logic            id_ALUSrc2,
  input  logic            id_RegWrite,
  input  logic [3:0]      id_ALUControl,
  input  logic [2:0]      id_MemRead,
  input  logic [2:0]      id_br_type,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            flush,
  input  logic            hold,
  output logic            ex_valid,
  output logic [1:0]      ex_ResultSrc,
  output logic [1:0]      ex_MemWrite,
  output logic            ex_ALUSrc1,
  output logic            ex_ALUSrc2,
  output logic            ex_RegWrite,
  output logic [3:0]      ex_ALUControl,
  output logic [2:0]      ex_MemRead,
  output logic [2:0]      ex_br_type,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic            load_use_stall
`ifdef LUMOS_HAZARD_CNT_EN
  ,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;
  logic slot_empty;

  // Load-use detection against the instruction currently held in EX
  always_comb begin
    ex_is_load     = ex_valid & ex_RegWrite & (ex_ResultSrc == 2'b01) & (ex_rd != '0);
    rs1_hit        = id_use_rs1 & (id_rs1 == ex_rd);
    rs2_hit        = id_use_rs2 & (id_rs2 == ex_rd);
    load_use_stall = id_valid & ex_is_load & (rs1_hit | rs2_hit) & ~flush & ~hold;
  end

  // flush and reset always empty the slot; otherwise a stall or an invalid
  // ID slot empties it only when the register is not held
  always_comb begin
    slot_empty = rst | flush | (~hold & (load_use_stall | ~id_valid));
  end

  // Pipeline register: bubble, hold or capture
  always_ff @(posedge clk) begin
    if (slot_empty) begin
      ex_valid      <= 1'b0;
      ex_ResultSrc  <= '0;
      ex_MemWrite   <= '0;
      ex_ALUSrc1    <= 1'b0;
      ex_ALUSrc2    <= 1'b0;
      ex_RegWrite   <= 1'b0;
      ex_ALUControl <= '0;
      ex_MemRead    <= '0;
      ex_br_type    <= '0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_ResultSrc  <= id_ResultSrc;
      ex_MemWrite   <= id_MemWrite;
      ex_ALUSrc1    <= id_ALUSrc1;
      ex_ALUSrc2    <= id_ALUSrc2;
      ex_RegWrite   <= id_RegWrite;
      ex_ALUControl <= id_ALUControl;
      ex_MemRead    <= id_MemRead;
      ex_br_type    <= id_br_type;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
    end
  end

`ifdef LUMOS_HAZARD_CNT_EN
  // Hazard event counters; load_use_stall is already masked by hold and
  // flush, so hold freezes bubble_cnt without extra gating
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (load_use_stall) bubble_cnt <= bubble_cnt + 32'd1;
      if (flush)          flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_ResultSrc, id_MemWrite;
  logic        id_ALUSrc1, id_ALUSrc2, id_RegWrite;
  logic [3:0]  id_ALUControl;
  logic [2:0]  id_MemRead, id_br_type;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, flush, hold;
  logic        ex_valid;
  logic [1:0]  ex_ResultSrc, ex_MemWrite;
  logic        ex_ALUSrc1, ex_ALUSrc2, ex_RegWrite;
  logic [3:0]  ex_ALUControl;
  logic [2:0]  ex_MemRead, ex_br_type;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        load_use_stall;
`ifdef LUMOS_HAZARD_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ResultSrc(id_ResultSrc), .id_MemWrite(id_MemWrite),
    .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2), .id_RegWrite(id_RegWrite),
    .id_ALUControl(id_ALUControl), .id_MemRead(id_MemRead), .id_br_type(id_br_type),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_ResultSrc(ex_ResultSrc), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2), .ex_RegWrite(ex_RegWrite),
    .ex_ALUControl(ex_ALUControl), .ex_MemRead(ex_MemRead), .ex_br_type(ex_br_type),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .load_use_stall(load_use_stall)
`ifdef LUMOS_HAZARD_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, hold, v;
    logic [1:0]  rsrc, mw;
    logic        rw;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] pc;
    logic        e_stall, e_v;
    logic [1:0]  e_rsrc, e_mw;
    logic        e_rw;
    logic [3:0]  e_alu;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Remaining control/data inputs are derived so that a bubble (pc=0,
  // rsrc=00, valid=0) maps to all-zero expectations
  task automatic drive(input vec_t t);
    rst           = t.rst;
    flush         = t.flush;
    hold          = t.hold;
    id_valid      = t.v;
    id_ResultSrc  = t.rsrc;
    id_MemWrite   = t.mw;
    id_RegWrite   = t.rw;
    id_ALUControl = t.alu;
    id_rs1        = t.rs1;
    id_rs2        = t.rs2;
    id_rd         = t.rd;
    id_use_rs1    = t.u1;
    id_use_rs2    = t.u2;
    id_pc         = t.pc;
    id_ALUSrc1    = 1'b1;
    id_ALUSrc2    = 1'b1;
    id_MemRead    = (t.rsrc == 2'b01) ? 3'b010 : 3'b000;
    id_br_type    = 3'b100;
    id_rs1_data   = t.pc << 1;
    id_rs2_data   = t.pc << 2;
    id_imm        = t.pc << 3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mk(output vec_t t,
                    input logic r, input logic f, input logic h, input logic v,
                    input logic [1:0] rsrc, input logic [1:0] mw, input logic rw,
                    input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic u1, input logic u2,
                    input logic [31:0] pc, input logic es, input logic ev,
                    input logic [1:0] ersrc, input logic [1:0] emw, input logic erw,
                    input logic [3:0] ealu, input logic [4:0] ers1, input logic [4:0] ers2,
                    input logic [4:0] erd, input logic [31:0] epc);
    t.rst = r; t.flush = f; t.hold = h; t.v = v; t.rsrc = rsrc; t.mw = mw; t.rw = rw;
    t.alu = alu; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2; t.pc = pc;
    t.e_stall = es; t.e_v = ev; t.e_rsrc = ersrc; t.e_mw = emw; t.e_rw = erw;
    t.e_alu = ealu; t.e_rs1 = ers1; t.e_rs2 = ers2; t.e_rd = erd; t.e_pc = epc;
  endtask

  initial begin
    vec_t z;
    // plain capture
    mk(vecs[0], 0,0,0,1, 2'b00,2'b00,1,4'h5, 5'd1,5'd2,5'd7, 1,1, 32'h100, 0, 1,2'b00,2'b00,1,4'h5,5'd1,5'd2,5'd7,32'h100);
    // lw x5, then dependent add on rs2: one bubble, then capture
    mk(vecs[1], 0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd2,5'd0,5'd5, 1,0, 32'h104, 0, 1,2'b01,2'b00,1,4'h0,5'd2,5'd0,5'd5,32'h104);
    mk(vecs[2], 0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd6,5'd5,5'd8, 1,1, 32'h108, 1, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    mk(vecs[3], 0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd6,5'd5,5'd8, 1,1, 32'h108, 0, 1,2'b00,2'b00,1,4'h0,5'd6,5'd5,5'd8,32'h108);
    // lw x0 then reader of x0: no stall
    mk(vecs[4], 0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd1,5'd0,5'd0, 1,0, 32'h10c, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd0,32'h10c);
    mk(vecs[5], 0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd0,5'd0,5'd9, 1,1, 32'h110, 0, 1,2'b00,2'b00,1,4'h0,5'd0,5'd0,5'd9,32'h110);
    // lw x5 then rs2=5 with use_rs2=0: no stall
    mk(vecs[6], 0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd1,5'd0,5'd5, 1,0, 32'h114, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd5,32'h114);
    mk(vecs[7], 0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd3,5'd5,5'd10, 1,0, 32'h118, 0, 1,2'b00,2'b00,1,4'h0,5'd3,5'd5,5'd10,32'h118);
    // lw x6, then flush coincident with a hit: single bubble, stall masked
    mk(vecs[8], 0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd1,5'd0,5'd6, 1,0, 32'h11c, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd6,32'h11c);
    mk(vecs[9], 0,1,0,1, 2'b00,2'b11,0,4'h0, 5'd6,5'd2,5'd0, 1,1, 32'h120, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    mk(vecs[10],0,0,0,1, 2'b00,2'b11,0,4'h0, 5'd6,5'd2,5'd0, 1,1, 32'h120, 0, 1,2'b00,2'b11,0,4'h0,5'd6,5'd2,5'd0,32'h120);
    // flush while ID has sw
    mk(vecs[11],0,1,0,1, 2'b00,2'b11,0,4'h0, 5'd1,5'd3,5'd0, 1,1, 32'h124, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    // lw x5, then hold x3 with a hit present: no stall, values frozen
    mk(vecs[12],0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd1,5'd0,5'd5, 1,0, 32'h128, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd5,32'h128);
    mk(vecs[13],0,0,1,1, 2'b00,2'b00,1,4'h0, 5'd4,5'd5,5'd11, 1,1, 32'h12c, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd5,32'h128);
    mk(vecs[14],0,0,1,1, 2'b00,2'b00,1,4'h3, 5'd7,5'd8,5'd12, 1,1, 32'h200, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd5,32'h128);
    mk(vecs[15],0,0,1,0, 2'b10,2'b01,0,4'h9, 5'd9,5'd9,5'd13, 0,0, 32'h204, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd5,32'h128);
    // hold released: the hit now stalls once
    mk(vecs[16],0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd4,5'd5,5'd11, 1,1, 32'h12c, 1, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    mk(vecs[17],0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd4,5'd5,5'd11, 1,1, 32'h12c, 0, 1,2'b00,2'b00,1,4'h0,5'd4,5'd5,5'd11,32'h12c);
    // invalid slot: nothing leaks
    mk(vecs[18],0,0,0,0, 2'b01,2'b11,1,4'ha, 5'd5,5'd6,5'd12, 1,1, 32'h130, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    // capture, hold, reset during hold
    mk(vecs[19],0,0,0,1, 2'b00,2'b00,1,4'h3, 5'd1,5'd2,5'd13, 1,1, 32'h134, 0, 1,2'b00,2'b00,1,4'h3,5'd1,5'd2,5'd13,32'h134);
    mk(vecs[20],0,0,1,1, 2'b01,2'b00,1,4'h0, 5'd13,5'd0,5'd14, 1,0, 32'h138, 0, 1,2'b00,2'b00,1,4'h3,5'd1,5'd2,5'd13,32'h134);
    mk(vecs[21],1,0,1,1, 2'b01,2'b00,1,4'h0, 5'd13,5'd0,5'd14, 1,0, 32'h138, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    // max field values, then lw x31 and rs1 dependency
    mk(vecs[22],0,0,0,1, 2'b10,2'b01,1,4'hf, 5'd31,5'd30,5'd31, 1,1, 32'h200, 0, 1,2'b10,2'b01,1,4'hf,5'd31,5'd30,5'd31,32'h200);
    mk(vecs[23],0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd1,5'd0,5'd31, 1,0, 32'h204, 0, 1,2'b01,2'b00,1,4'h0,5'd1,5'd0,5'd31,32'h204);
    mk(vecs[24],0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd31,5'd0,5'd1, 1,0, 32'h208, 1, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    mk(vecs[25],0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd31,5'd0,5'd1, 1,0, 32'h208, 0, 1,2'b00,2'b00,1,4'h0,5'd31,5'd0,5'd1,32'h208);

    // Reset for two cycles with random ID contents
    mk(z, 1,0,0,1, 2'b01,2'b11,1,4'hf, 5'd5,5'd5,5'd5, 1,1, 32'h0, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
    drive(z);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      z.pc  = $urandom;
      z.rd  = 5'($urandom_range(1, 31));
      z.alu = 4'($urandom);
      drive(z);
      step();
      chk($sformatf("rst%0d_valid", c), 32'(ex_valid), 32'd0);
      chk($sformatf("rst%0d_pc", c), ex_pc, 32'd0);
      chk($sformatf("rst%0d_rd", c), 32'(ex_rd), 32'd0);
      chk($sformatf("rst%0d_ctl", c), {20'd0, ex_RegWrite, ex_MemWrite, ex_ResultSrc, ex_MemRead, ex_ALUControl},
          32'd0);
      chk($sformatf("rst%0d_data", c), ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
      chk($sformatf("rst%0d_stall", c), 32'(load_use_stall), 32'd0);
    end

    // Table-driven vectors
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(load_use_stall), 32'(vecs[i].e_stall));
      step();
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_rsrc", i), 32'(ex_ResultSrc), 32'(vecs[i].e_rsrc));
      chk($sformatf("v%0d_mw", i), 32'(ex_MemWrite), 32'(vecs[i].e_mw));
      chk($sformatf("v%0d_rw", i), 32'(ex_RegWrite), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_alu", i), 32'(ex_ALUControl), 32'(vecs[i].e_alu));
      chk($sformatf("v%0d_rs1", i), 32'(ex_rs1), 32'(vecs[i].e_rs1));
      chk($sformatf("v%0d_rs2", i), 32'(ex_rs2), 32'(vecs[i].e_rs2));
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_alusrc", i), 32'({ex_ALUSrc1, ex_ALUSrc2}), vecs[i].e_v ? 32'd3 : 32'd0);
      chk($sformatf("v%0d_memread", i), 32'(ex_MemRead),
          (vecs[i].e_v && vecs[i].e_rsrc == 2'b01) ? 32'd2 : 32'd0);
      chk($sformatf("v%0d_br", i), 32'(ex_br_type), vecs[i].e_v ? 32'd4 : 32'd0);
      chk($sformatf("v%0d_rs1d", i), ex_rs1_data, vecs[i].e_pc << 1);
      chk($sformatf("v%0d_rs2d", i), ex_rs2_data, vecs[i].e_pc << 2);
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].e_pc << 3);
    end

`ifdef LUMOS_HAZARD_CNT_EN
    begin
      vec_t lw, use_, fl;
      mk(lw,   0,0,0,1, 2'b01,2'b00,1,4'h0, 5'd1,5'd0,5'd5, 1,0, 32'h300, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
      mk(use_, 0,0,0,1, 2'b00,2'b00,1,4'h0, 5'd2,5'd5,5'd6, 1,1, 32'h304, 0, 0,2'b00,2'b00,0,4'h0,5'd0,5'd0,5'd0,32'h0);
      fl = use_;
      fl.flush = 1'b1;
      @(negedge clk);
      z.rst = 1'b1;
      drive(z);
      step();
      chk("cnt_rst_bubble", bubble_cnt, 32'd0);
      chk("cnt_rst_flush", flush_cnt, 32'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); drive(lw);   step();
        @(negedge clk); drive(use_); step();
      end
      // hold must freeze both counters
      @(negedge clk); drive(lw); step();
      @(negedge clk); use_.hold = 1'b1; drive(use_); step(); step();
      use_.hold = 1'b0;
      @(negedge clk); drive(fl); step();
      @(negedge clk); drive(fl); step();
      chk("cnt_bubble4", bubble_cnt, 32'd4);
      chk("cnt_flush2", flush_cnt, 32'd2);
      @(negedge clk); drive(lw); step();
      @(negedge clk);
      force dut.bubble_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.bubble_cnt;
      drive(use_);
      step();
      chk("cnt_wrap", bubble_cnt, 32'd0);
      chk("cnt_flush_kept", flush_cnt, 32'd2);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
